idu_fetch_queue: RTL and testbench

- Parametrised multi-entry instruction queue between fetch and the decode/rename stage.
- Successor to the single-entry stall register in the decode front end.
- Accepts up to FETCH_WIDTH instructions per cycle, with a per-slot valid mask, and compacts them in program order into a circular buffer.
- Presents one instruction per cycle to decode. Decode back-pressure (stall) and pipeline flush are handled without losing or duplicating instructions.

---
 rtl/idu_fetch_queue.sv | 102 ++++++++++
 tb/tb_idu_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/idu_fetch_queue.sv
// idu_fetch_queue: multi-entry instruction queue between fetch and decode.
// Fetch bundles of up to FETCH_WIDTH slots are compacted in program order into
// a circular buffer; decode pops one instruction per cycle from the head.
module idu_fetch_queue #(
  parameter int FETCH_WIDTH     = 2,
  parameter int DEPTH           = 8,
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [FETCH_WIDTH-1:0]     fetch_mask,
  input  logic [INST_WIDTH-1:0]      fetch_inst [FETCH_WIDTH],
  input  logic [INST_ADDR_WIDTH-1:0] fetch_pc,
  output logic                       fetch_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       deq_valid,
  output logic [INST_WIDTH-1:0]      deq_inst,
  output logic [INST_ADDR_WIDTH-1:0] deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       queue_full,
  output logic                       queue_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [INST_WIDTH-1:0]      r_inst [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [PW-1:0]              r_head;
  logic [PW-1:0]              r_tail;
  logic [OW-1:0]              r_occ;

  logic [OW-1:0]              w_n;
  logic [PW-1:0]              w_idx     [FETCH_WIDTH];
  logic [INST_ADDR_WIDTH-1:0] w_slot_pc [FETCH_WIDTH];
  logic [OW-1:0]              w_free;
  logic                       w_enq;
  logic                       w_deq;

  // Compaction: each set slot lands at tail + (number of set slots below it).
  always_comb begin
    w_n = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      w_idx[i]     = r_tail + PW'(w_n);
      w_slot_pc[i] = fetch_pc + INST_ADDR_WIDTH'(4 * i);
      w_n          = w_n + OW'(fetch_mask[i]);
    end
  end

  assign w_free      = OW'(DEPTH) - r_occ;
  assign fetch_ready = (w_free >= OW'(FETCH_WIDTH));
  assign queue_empty = (r_occ == '0);
  assign queue_full  = (r_occ == OW'(DEPTH));
  assign deq_valid   = ~queue_empty;
  assign occupancy   = r_occ;

  // Flush gates both directions; fetch_ready already guarantees room for n.
  assign w_enq = fetch_valid & fetch_ready & ~flush;
  assign w_deq = deq_valid & ~stall & ~flush;

  // Head is gated on empty since flush leaves stale storage behind.
  assign deq_inst = queue_empty ? '0 : r_inst[r_head];
  assign deq_pc   = queue_empty ? '0 : r_pc[r_head];

  // Storage write of the compacted bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned d = 0; d < DEPTH; d++) begin
        r_inst[d] <= '0;
        r_pc[d]   <= '0;
      end
    end else if (w_enq) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (fetch_mask[i]) begin
          r_inst[w_idx[i]] <= fetch_inst[i];
          r_pc[w_idx[i]]   <= w_slot_pc[i];
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush returns both pointers to entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(w_n);
      if (w_deq) r_head <= r_head + 1'b1;
      r_occ <= r_occ + (w_enq ? w_n : '0) - OW'(w_deq);
    end
  end

endmodule

// File: tb/tb_idu_fetch_queue.sv
// tb_idu_fetch_queue: directed vector table plus streaming and reset sequences.
module tb_idu_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [1:0]  fetch_mask;
  logic [31:0] fetch_inst [2];
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        stall;
  logic        flush;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [3:0]  occupancy;
  logic        queue_full;
  logic        queue_empty;

  int n_vec = 0;
  int n_err = 0;

  idu_fetch_queue #(
    .FETCH_WIDTH(2),
    .DEPTH(8),
    .INST_WIDTH(32),
    .INST_ADDR_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_valid(fetch_valid),
    .fetch_mask(fetch_mask),
    .fetch_inst(fetch_inst),
    .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .flush(flush),
    .deq_valid(deq_valid),
    .deq_inst(deq_inst),
    .deq_pc(deq_pc),
    .occupancy(occupancy),
    .queue_full(queue_full),
    .queue_empty(queue_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [1:0]  mask;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    int          e_occ;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t V(logic fv, logic [1:0] mask, logic [31:0] i0, logic [31:0] i1,
                             logic [31:0] pc, logic st, logic fl,
                             int e_occ, logic [31:0] e_inst, logic [31:0] e_pc);
    vec_t v;
    v.fv = fv; v.mask = mask; v.i0 = i0; v.i1 = i1; v.pc = pc; v.st = st; v.fl = fl;
    v.e_occ = e_occ; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Checks every output against an expected occupancy and head entry.
  task automatic chk_state(input string tag, input int occ, input logic [31:0] inst,
                           input logic [31:0] pc);
    chk({tag, ".occ"},   32'(occupancy),   32'(occ));
    chk({tag, ".dv"},    32'(deq_valid),   32'(occ != 0));
    chk({tag, ".inst"},  deq_inst,         inst);
    chk({tag, ".pc"},    deq_pc,           pc);
    chk({tag, ".empty"}, 32'(queue_empty), 32'(occ == 0));
    chk({tag, ".full"},  32'(queue_full),  32'(occ == 8));
    chk({tag, ".rdy"},   32'(fetch_ready), 32'((8 - occ) >= 2));
  endtask

  task automatic drive(input logic fv, input logic [1:0] mask, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc, input logic st,
                       input logic fl);
    fetch_valid   = fv;
    fetch_mask    = mask;
    fetch_inst[0] = i0;
    fetch_inst[1] = i1;
    fetch_pc      = pc;
    stall         = st;
    flush         = fl;
  endtask

  vec_t tbl [29];
  logic [31:0] q [$];
  logic [1:0]  pat [4];

  initial begin
    // Expected values describe the state right after the edge that consumed the vector.
    tbl[0]  = V(0, 2'b00, 0, 0, 0, 0, 0,         0, 0, 0);
    tbl[1]  = V(1, 2'b11, 'hA, 'hB, 'h100, 0, 0, 2, 'hA, 'h100);
    tbl[2]  = V(0, 2'b00, 0, 0, 0, 0, 0,         1, 'hB, 'h104);
    tbl[3]  = V(0, 2'b00, 0, 0, 0, 0, 0,         0, 0, 0);
    tbl[4]  = V(1, 2'b10, 'hC, 'hD, 'h200, 0, 0, 1, 'hD, 'h204);
    tbl[5]  = V(0, 2'b00, 0, 0, 0, 0, 0,         0, 0, 0);
    tbl[6]  = V(1, 2'b11, 'h11, 'h12, 'h300, 1, 0, 2, 'h11, 'h300);
    tbl[7]  = V(1, 2'b11, 'h13, 'h14, 'h308, 1, 0, 4, 'h11, 'h300);
    tbl[8]  = V(1, 2'b11, 'h15, 'h16, 'h310, 1, 0, 6, 'h11, 'h300);
    tbl[9]  = V(1, 2'b01, 'h17, 'h99, 'h318, 1, 0, 7, 'h11, 'h300);
    tbl[10] = V(1, 2'b11, 'h18, 'h19, 'h320, 1, 0, 7, 'h11, 'h300);
    tbl[11] = V(0, 2'b00, 0, 0, 0, 0, 0,         6, 'h12, 'h304);
    tbl[12] = V(0, 2'b00, 0, 0, 0, 0, 0,         5, 'h13, 'h308);
    tbl[13] = V(0, 2'b00, 0, 0, 0, 0, 0,         4, 'h14, 'h30c);
    tbl[14] = V(0, 2'b00, 0, 0, 0, 0, 0,         3, 'h15, 'h310);
    tbl[15] = V(0, 2'b00, 0, 0, 0, 0, 0,         2, 'h16, 'h314);
    tbl[16] = V(0, 2'b00, 0, 0, 0, 0, 0,         1, 'h17, 'h318);
    tbl[17] = V(0, 2'b00, 0, 0, 0, 0, 0,         0, 0, 0);
    tbl[18] = V(1, 2'b11, 'h21, 'h22, 'h400, 1, 0, 2, 'h21, 'h400);
    tbl[19] = V(1, 2'b11, 'h23, 'h24, 'h408, 1, 0, 4, 'h21, 'h400);
    tbl[20] = V(1, 2'b11, 'h25, 'h26, 'h410, 1, 0, 6, 'h21, 'h400);
    tbl[21] = V(1, 2'b11, 'h27, 'h28, 'h418, 1, 0, 8, 'h21, 'h400);
    tbl[22] = V(0, 2'b00, 0, 0, 0, 0, 0,         7, 'h22, 'h404);
    tbl[23] = V(0, 2'b00, 0, 0, 0, 0, 0,         6, 'h23, 'h408);
    tbl[24] = V(0, 2'b00, 0, 0, 0, 0, 0,         5, 'h24, 'h40c);
    tbl[25] = V(1, 2'b11, 'h31, 'h32, 'h500, 0, 1, 0, 0, 0);
    tbl[26] = V(1, 2'b11, 'h41, 'h42, 'h600, 0, 0, 2, 'h41, 'h600);
    tbl[27] = V(0, 2'b00, 0, 0, 0, 0, 0,         1, 'h42, 'h604);
    tbl[28] = V(0, 2'b00, 0, 0, 0, 0, 0,         0, 0, 0);

    drive(0, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12;
    chk_state("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 29; k++) begin
      drive(tbl[k].fv, tbl[k].mask, tbl[k].i0, tbl[k].i1, tbl[k].pc, tbl[k].st, tbl[k].fl);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", k), tbl[k].e_occ, tbl[k].e_inst, tbl[k].e_pc);
    end

    // Streaming: prefill 4 under stall, then 20 cycles of mixed masks averaging one
    // enqueue per cycle against one dequeue per cycle, so the pointers wrap.
    begin
      logic [31:0] next_pc;
      logic [31:0] bpc;
      logic [1:0]  m;
      logic        st;
      logic        rdy_exp;
      pat[0] = 2'b11; pat[1] = 2'b00; pat[2] = 2'b01; pat[3] = 2'b10;
      next_pc = 32'h1000;
      for (int c = 0; c < 34; c++) begin
        if (c < 2) begin m = 2'b11; st = 1'b1; end
        else if (c < 22) begin m = pat[(c - 2) % 4]; st = 1'b0; end
        else begin m = 2'b00; st = 1'b0; end
        bpc = (m == 2'b10) ? next_pc - 32'd4 : next_pc;
        drive(m != 2'b00, m, bpc ^ 32'hDEAD0000, (bpc + 32'd4) ^ 32'hDEAD0000, bpc, st, 0);
        rdy_exp = (8 - q.size()) >= 2;
        chk($sformatf("stream%0d.rdy", c), 32'(fetch_ready), 32'(rdy_exp));
        @(posedge clk);
        #1;
        if (q.size() > 0 && !st) void'(q.pop_front());
        if (m != 2'b00 && rdy_exp) begin
          for (int s = 0; s < 2; s++) begin
            if (m[s]) begin
              q.push_back(bpc + 32'(4 * s));
              next_pc = next_pc + 32'd4;
            end
          end
        end
        chk($sformatf("stream%0d.occ", c), 32'(occupancy), 32'(q.size()));
        if (q.size() > 0) begin
          chk($sformatf("stream%0d.pc", c),   deq_pc,   q[0]);
          chk($sformatf("stream%0d.inst", c), deq_inst, q[0] ^ 32'hDEAD0000);
        end else begin
          chk($sformatf("stream%0d.dv", c), 32'(deq_valid), 32'd0);
        end
      end
      chk("stream.drained", 32'(queue_empty), 32'd1);
      chk("stream.total", next_pc, 32'h1000 + 32'd4 * 32'd24);
    end

    // Asynchronous reset in the middle of a cycle while four entries are held.
    drive(1, 2'b11, 'h51, 'h52, 'h700, 1, 0);
    @(posedge clk);
    #1;
    drive(1, 2'b11, 'h53, 'h54, 'h708, 1, 0);
    @(posedge clk);
    #1;
    chk_state("prerst", 4, 'h51, 'h700);
    drive(0, 2'b00, 0, 0, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_state("midrst", 0, 0, 0);
    chk("midrst.store", dut.r_inst[2], 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 2'b11, 'h61, 'h62, 'h800, 1, 0);
    @(posedge clk);
    #1;
    chk_state("postrst", 2, 'h61, 'h800);
    chk("postrst.e0", dut.r_inst[0], 32'h61);
    chk("postrst.e1pc", dut.r_pc[1], 32'h804);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
